mac_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `mac_tx` transmit path between two dibit-stream frame sources. It grants the MAC to one source per frame and forwards that source's valid, data and ready with zero latency. After each frame it holds off further grants until the MAC's CRC and inter-frame gap have completed. A per-frame dibit watchdog truncates runaway sources so one requester cannot monopolise the PHY.

---
 rtl/mac_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_mac_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter sharing one mac_tx transmit path between two dibit frame sources.
// Grants per frame, forwards with zero latency, enforces a post-frame guard and a length watchdog.
module mac_tx_arbiter #(
    parameter int unsigned GUARD_CYCLES     = 72,
    parameter int unsigned MAX_FRAME_DIBITS = 6100
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       src0_valid_i,
    input  logic [1:0] src0_din_i,
    output logic       src0_ready_o,
    input  logic       src1_valid_i,
    input  logic [1:0] src1_din_i,
    output logic       src1_ready_o,
    output logic       mac_valid_o,
    output logic [1:0] mac_din_o,
    input  logic       mac_ready_i,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic       trunc_o,
    output logic       err_o
);

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [15:0] MaxCnt = 16'(MAX_FRAME_DIBITS);
    localparam logic [GW-1:0] GuardLast = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLock, StStream, StHoldoff} state_e;

    state_e        state_q;
    logic [1:0]    grant_q;
    logic          last_q;
    logic [15:0]   cnt_q;
    logic [GW-1:0] guard_q;
    logic [1:0]    mask_q;
    logic          trunc_q;
    logic          err_q;

    logic [1:0] src_valid;
    logic [1:0] elig;
    logic       pick;
    logic       gidx;
    logic       sel_valid;
    logic [1:0] sel_din;
    logic       at_limit;
    logic       fwd;
    logic       rdy;

    always_comb begin
        src_valid = {src1_valid_i, src0_valid_i};
        elig      = src_valid & ~mask_q;
        pick      = (elig == 2'b11) ? ~last_q : elig[1];
        gidx      = grant_q[1];
        sel_valid = gidx ? src1_valid_i : src0_valid_i;
        sel_din   = gidx ? src1_din_i : src0_din_i;
        // Once the watchdog limit is reached the frame is frozen for one cycle before HOLDOFF.
        at_limit  = (cnt_q == MaxCnt);
        fwd       = (state_q == StLock) || ((state_q == StStream) && !at_limit);
        rdy       = (state_q == StStream) && !at_limit && mac_ready_i;
    end

    assign mac_valid_o  = fwd & sel_valid;
    assign mac_din_o    = fwd ? sel_din : 2'b00;
    assign src0_ready_o = rdy & grant_q[0];
    assign src1_ready_o = rdy & grant_q[1];
    assign grant_o      = grant_q;
    assign busy_o       = (state_q != StIdle);
    assign trunc_o      = trunc_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            guard_q <= '0;
            mask_q  <= 2'b00;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= mask_q & src_valid;
            unique case (state_q)
                StIdle: begin
                    if (elig != 2'b00) begin
                        grant_q <= pick ? 2'b10 : 2'b01;
                        last_q  <= pick;
                        cnt_q   <= '0;
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    if (!sel_valid) begin
                        err_q   <= 1'b1;
                        grant_q <= 2'b00;
                        guard_q <= '0;
                        state_q <= StHoldoff;
                    end else if (mac_ready_i) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (!sel_valid) begin
                        grant_q <= 2'b00;
                        guard_q <= '0;
                        state_q <= StHoldoff;
                    end else if (at_limit) begin
                        trunc_q      <= 1'b1;
                        mask_q[gidx] <= 1'b1;
                        grant_q      <= 2'b00;
                        guard_q      <= '0;
                        state_q      <= StHoldoff;
                    end else if (mac_ready_i) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StHoldoff: begin
                    if (guard_q == GuardLast) begin
                        state_q <= StIdle;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: two instances (long and 4-dibit watchdog) driven by shared stimulus
// and compared every cycle against a transaction-level model of the arbitration rules.
module tb_mac_tx_arbiter;

    localparam int G    = 72;
    localparam int MAXA = 6100;
    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       s0v, s1v, mrdy;
    logic [1:0] s0d, s1d;

    logic       a_r0, a_r1, a_mv, a_busy, a_trunc, a_err;
    logic [1:0] a_md, a_grant;
    logic       b_r0, b_r1, b_mv, b_busy, b_trunc, b_err;
    logic [1:0] b_md, b_grant;

    always #5 clk = ~clk;

    mac_tx_arbiter #(.GUARD_CYCLES(G), .MAX_FRAME_DIBITS(MAXA)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .src0_valid_i(s0v), .src0_din_i(s0d), .src0_ready_o(a_r0),
        .src1_valid_i(s1v), .src1_din_i(s1d), .src1_ready_o(a_r1),
        .mac_valid_o(a_mv), .mac_din_o(a_md), .mac_ready_i(mrdy),
        .grant_o(a_grant), .busy_o(a_busy), .trunc_o(a_trunc), .err_o(a_err)
    );

    mac_tx_arbiter #(.GUARD_CYCLES(G), .MAX_FRAME_DIBITS(MAXB)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .src0_valid_i(s0v), .src0_din_i(s0d), .src0_ready_o(b_r0),
        .src1_valid_i(s1v), .src1_din_i(s1d), .src1_ready_o(b_r1),
        .mac_valid_o(b_mv), .mac_din_o(b_md), .mac_ready_i(mrdy),
        .grant_o(b_grant), .busy_o(b_busy), .trunc_o(b_trunc), .err_o(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: owner (-1 = none), whether the MAC has signalled ready, frame handshakes,
    // remaining guard cycles, per-source masks and the last served source.
    typedef struct {
        int       owner;
        bit       seen;
        int       hs;
        int       cool;
        bit [1:0] mask;
        int       last;
        bit       trunc;
        bit       err;
    } mdl_t;

    typedef struct {
        logic [1:0] grant;
        logic       busy, trunc, err, mv, r0, r1;
        logic [1:0] md;
    } obs_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.owner = -1; m.seen = 0; m.hs = 0; m.cool = 0;
        m.mask = 2'b00; m.last = 1; m.trunc = 0; m.err = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit [1:0] v, bit rdy, int maxd);
        mdl_t n = m;
        bit [1:0] elig;
        bit end_frame = 0;
        n.trunc = 0;
        n.err   = 0;
        for (int i = 0; i < 2; i++) if (!v[i]) n.mask[i] = 0;
        if (m.cool > 0) begin
            n.cool = m.cool - 1;
        end else if (m.owner < 0) begin
            elig = v & ~m.mask;
            if (elig != 0) begin
                n.owner = (elig == 2'b11) ? 1 - m.last : (elig[1] ? 1 : 0);
                n.last  = n.owner;
                n.seen  = 0;
                n.hs    = 0;
            end
        end else if (!m.seen) begin
            if (!v[m.owner]) begin
                n.err = 1;
                end_frame = 1;
            end else if (rdy) begin
                n.seen = 1;
            end
        end else begin
            if (!v[m.owner]) begin
                end_frame = 1;
            end else if (m.hs == maxd) begin
                n.trunc = 1;
                n.mask[m.owner] = 1;
                end_frame = 1;
            end else if (rdy) begin
                n.hs = m.hs + 1;
            end
        end
        if (end_frame) begin
            n.owner = -1;
            n.cool  = G;
        end
        return n;
    endfunction

    function automatic obs_t mout(mdl_t m, bit [1:0] v, bit [1:0] d0, bit [1:0] d1, bit rdy,
                                  int maxd);
        obs_t e;
        bit live = (m.owner >= 0) && (!m.seen || m.hs < maxd);
        bit open = (m.owner >= 0) && m.seen && (m.hs < maxd) && rdy;
        e.grant = (m.owner < 0) ? 2'b00 : (m.owner == 0 ? 2'b01 : 2'b10);
        e.busy  = (m.owner >= 0) || (m.cool > 0);
        e.trunc = m.trunc;
        e.err   = m.err;
        e.mv    = live && v[m.owner == 1];
        e.md    = live ? (m.owner == 1 ? d1 : d0) : 2'b00;
        e.r0    = open && (m.owner == 0);
        e.r1    = open && (m.owner == 1);
        return e;
    endfunction

    mdl_t ma, mb;
    obs_t oa, ob;

    task automatic cmp(input string dn, input obs_t o, input obs_t e);
        check_eq({dn, "_grant"}, 16'(o.grant), 16'(e.grant));
        check_eq({dn, "_busy"},  16'(o.busy),  16'(e.busy));
        check_eq({dn, "_trunc"}, 16'(o.trunc), 16'(e.trunc));
        check_eq({dn, "_err"},   16'(o.err),   16'(e.err));
        check_eq({dn, "_mvalid"}, 16'(o.mv),   16'(e.mv));
        check_eq({dn, "_mdin"},  16'(o.md),    16'(e.md));
        check_eq({dn, "_rdy0"},  16'(o.r0),    16'(e.r0));
        check_eq({dn, "_rdy1"},  16'(o.r1),    16'(e.r1));
    endtask

    // One clock cycle: drive on the falling edge, check outputs 1 ns later, advance model.
    task automatic cycle(input bit rst, input bit v0, input bit [1:0] d0, input bit v1,
                         input bit [1:0] d1, input bit rdy);
        @(negedge clk);
        reset = rst; s0v = v0; s0d = d0; s1v = v1; s1d = d1; mrdy = rdy;
        if (rst) begin
            ma = mreset();
            mb = mreset();
        end
        #1;
        oa = '{grant: a_grant, busy: a_busy, trunc: a_trunc, err: a_err, mv: a_mv, md: a_md,
               r0: a_r0, r1: a_r1};
        ob = '{grant: b_grant, busy: b_busy, trunc: b_trunc, err: b_err, mv: b_mv, md: b_md,
               r0: b_r0, r1: b_r1};
        cmp("a", oa, mout(ma, {v1, v0}, d0, d1, rdy, MAXA));
        cmp("b", ob, mout(mb, {v1, v0}, d0, d1, rdy, MAXB));
        @(posedge clk);
        if (!rst) begin
            ma = mstep(ma, {v1, v0}, rdy, MAXA);
            mb = mstep(mb, {v1, v0}, rdy, MAXB);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            cycle(0, 0, 0, 0, 0, 0);
            n++;
        end while ((oa.busy || ob.busy) && n < 400);
        check_eq("idle_reached", 16'(oa.busy | ob.busy), 16'd0);
    endtask

    initial begin
        bit [1:0] seq [8];
        int k, cnt, gap, ng, tcount;
        int hs [2];
        bit drop [2];
        bit [1:0] prev_g, gl [4];
        bit v0r, v1r;
        int t0, t1;
        bit rdy;

        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        reset = 1'b1; s0v = 0; s1v = 0; s0d = 0; s1d = 0; mrdy = 0;
        ma = mreset(); mb = mreset();

        cycle(1, 0, 0, 0, 0, 0);
        check_eq("rst_busy", 16'(oa.busy), 16'd0);
        check_eq("rst_grant", 16'(oa.grant), 16'd0);
        cycle(0, 0, 0, 0, 0, 0);

        // src0 alone, 8 dibits with irregular mac_ready.
        k = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            rdy = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            cycle(0, 1, seq[k], 0, 0, rdy);
            if (c == 1) check_eq("grant_latency", 16'(oa.grant), 16'b01);
            check_eq("rdy0_needs_mac_ready", 16'(oa.r0 & ~rdy), 16'd0);
            if (oa.r0) begin
                check_eq("din_seq", 16'(oa.md), 16'(seq[k]));
                k++;
            end
        end
        check_eq("dibits_sent", 16'(k), 16'd8);
        cycle(0, 0, 0, 0, 0, 1);
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            cycle(0, 0, 0, 0, 0, 0);
            if (!oa.busy) break;
            cnt++;
        end
        check_eq("busy_after_fall", 16'(cnt), 16'(G));
        wait_idle();

        // Both request continuously, each dropping valid for one cycle after 4 dibits.
        hs = '{0, 0}; drop = '{0, 0}; ng = 0; prev_g = 0; gap = 0;
        for (int c = 0; c < 3000 && ng < 4; c++) begin
            cycle(0, !drop[0], 2'($urandom), !drop[1], 2'($urandom), 1);
            for (int i = 0; i < 2; i++) begin
                if (drop[i]) drop[i] = 0;
                if ((i == 0 && oa.r0) || (i == 1 && oa.r1)) hs[i]++;
                if (hs[i] == 4) begin
                    hs[i] = 0;
                    drop[i] = 1;
                end
            end
            if (oa.grant == 0) gap++;
            if (oa.grant != 0 && prev_g == 0) begin
                gl[ng] = oa.grant;
                if (ng > 0) check_eq("frame_gap", 16'(gap), 16'(G + 1));
                ng++;
            end
            if (oa.grant != 0) gap = 0;
            prev_g = oa.grant;
        end
        check_eq("alt_count", 16'(ng), 16'd4);
        check_eq("alt_first", 16'(gl[0]), 16'b10);
        for (int i = 1; i < 4; i++) check_eq("alt_order", 16'(gl[i]), 16'(gl[i-1] ^ 2'b11));
        wait_idle();

        // Watchdog on the 4-dibit instance: src0 never drops, src1 joins later.
        tcount = 0; prev_g = 0; ng = 0;
        for (int c = 0; c < 120; c++) begin
            cycle(0, 1, 2'($urandom), c >= 10, 2'($urandom), 1);
            tcount += int'(ob.trunc);
            if (ob.grant != 0 && prev_g == 0 && tcount > 0 && ng == 0) begin
                check_eq("trunc_once", 16'(tcount), 16'd1);
                check_eq("regrant_other", 16'(ob.grant), 16'b10);
                ng++;
            end
            prev_g = ob.grant;
        end
        check_eq("regrant_seen", 16'(ng), 16'd1);
        wait_idle();

        // src0 drops valid while still in LOCK.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("lock_grant", 16'(oa.grant), 16'b01);
        cycle(0, 0, 0, 0, 0, 1);
        check_eq("err_pulse", 16'(oa.err), 16'd1);
        check_eq("err_no_hs", 16'(oa.r0), 16'd0);
        cycle(0, 0, 0, 0, 0, 1);
        check_eq("err_single", 16'(oa.err), 16'd0);
        wait_idle();

        // Reset mid-stream after 3 dibits, then tie and lone-src1 after release.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) cycle(0, 1, 2'(c + 1), 0, 0, 1);
        cycle(1, 1, 2'd3, 0, 0, 1);
        check_eq("rst_mvalid", 16'(oa.mv), 16'd0);
        check_eq("rst_grant_mid", 16'(oa.grant), 16'd0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("tie_after_rst", 16'(oa.grant), 16'b01);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check_eq("src1_after_rst", 16'(oa.grant), 16'b10);
        wait_idle();

        // Randomised traffic with occasional resets.
        v0r = 0; v1r = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 4000; c++) begin
            if (t0 == 0) begin
                v0r = ~v0r;
                t0 = v0r ? $urandom_range(1, 14) : $urandom_range(1, 6);
            end
            if (t1 == 0) begin
                v1r = ~v1r;
                t1 = v1r ? $urandom_range(1, 14) : $urandom_range(1, 6);
            end
            t0--; t1--;
            cycle($urandom_range(0, 999) == 0, v0r, 2'($urandom), v1r, 2'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
